// File: rtl/sub_16bit_serial_pkg.sv
// Shared constants and types for the slice-serial 16-bit subtractor.
// Widths, FSM encoding and the slice-index type used by the top and its slice.
package sub_16bit_serial_pkg;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = $clog2(NSLICE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [KW-1:0] idx_t;

endpackage

// File: rtl/sub_16bit_serial_cla4.sv
// Combinational 4-bit carry-lookahead slice computing a + ~b + cin.
// Every carry is a flat sum of generate/propagate products, so none ripples.
module sub_slice_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] bn;
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign bn = ~b;
    assign g  = a & bn;
    assign p  = a ^ bn;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ c;

endmodule

// File: rtl/sub_16bit_serial.sv
// Multi-cycle 16-bit subtractor: diff = in1 - in2 - bin, one 4-bit slice per clock.
// A single lookahead slice is shared across slices, selected by the index k.
module sub_16bit_serial
    import sub_16bit_serial_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    state_t state;
    state_t state_nxt;
    idx_t   k;

    logic [NSLICE-1:0][SLICE-1:0] a_q;
    logic [NSLICE-1:0][SLICE-1:0] b_q;
    logic [NSLICE-1:0][SLICE-1:0] p_q;
    logic                         c;

    logic [SLICE-1:0] s;
    logic             c_nxt;
    logic             last;
    logic             accept;

    assign last   = (k == idx_t'(NSLICE - 1));
    assign accept = start && (state != CALC);
    assign busy   = (state == CALC);
    assign done   = (state == DONE);

    sub_slice_cla4 u_slice (
        .a    (a_q[k]),
        .b    (b_q[k]),
        .cin  (c),
        .s    (s),
        .cout (c_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The subtraction carry starts at ~bin; the final borrow is its inverse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            p_q  <= '0;
            c    <= 1'b0;
            k    <= '0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            a_q <= in1;
            b_q <= in2;
            c   <= ~bin;
            k   <= '0;
        end else if (state == CALC) begin
            p_q[k] <= s;
            c      <= c_nxt;
            k      <= k + idx_t'(1);
            if (last) begin
                diff <= {s, p_q[NSLICE-2:0]};
                bout <= ~c_nxt;
                ovf  <= (a_q[NSLICE-1][SLICE-1] != b_q[NSLICE-1][SLICE-1])
                     && (s[SLICE-1] != a_q[NSLICE-1][SLICE-1]);
            end
        end
    end

endmodule

// File: tb/tb_sub_16bit_serial.sv
// Scoreboard bench for sub_16bit_serial: directed cases, mid-op reset, random sweep.
// Expected results are queued at issue and compared whenever done is seen.
module tb_sub_16bit_serial;

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;

    sub_16bit_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        logic [16:0] r;
        r = {1'b0, a} - {1'b0, b} - 17'(bi);
        model.d  = r[15:0];
        model.bo = r[16];
        model.ov = (a[15] != b[15]) && (r[15] != a[15]);
    endfunction

    // Caller guarantees busy=0 and that the next clock edge has not yet arrived.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bi, input exp_t e);
        in1   = a;
        in2   = b;
        bin   = bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in1   = 16'($urandom);
        in2   = 16'($urandom);
        bin   = 1'($urandom);
        sb.push_back(e);
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("done_seen", 32'(got), 32'd1);
    endtask

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("done_with_empty_sb", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("diff", 32'(diff), 32'(mon_e.d));
                chk("bout", 32'(bout), 32'(mon_e.bo));
                chk("ovf",  32'(ovf),  32'(mon_e.ov));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [15:0] ra, rb;
        logic        rbi;

        rst_n = 1'b0;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        rst_n = 1'b1;

        // Basic case with cycle-exact busy/done timing.
        issue(16'h1234, 16'h0034, 1'b0, '{16'h1200, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) begin
            chk("busy_win", 32'(busy), 32'd1);
            chk("done_win", 32'(done), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("busy_end", 32'(busy), 32'd0);
        chk("done_end", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(done), 32'd0);

        issue(16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0});
        wait_done();
        issue(16'h0005, 16'h0003, 1'b1, '{16'h0001, 1'b0, 1'b0});
        wait_done();
        issue(16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b1, 1'b0});
        wait_done();

        // Start while busy is dropped; then back-to-back start in the DONE cycle.
        issue(16'h00FF, 16'h0001, 1'b0, '{16'h00FE, 1'b0, 1'b0});
        in1   = 16'hAAAA;
        in2   = 16'h5555;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        issue(16'hFFFF, 16'hFFFF, 1'b0, '{16'h0000, 1'b0, 1'b0});
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done();

        issue(16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1});
        wait_done();
        issue(16'h7FFF, 16'hFFFF, 1'b0, '{16'h8000, 1'b1, 1'b1});
        wait_done();

        // Asynchronous reset after two committed slices.
        @(posedge clk);
        #1;
        issue(16'h1111, 16'h2222, 1'b0, '{16'hEEEF, 1'b1, 1'b0});
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_bout", 32'(bout), 32'd0);
        chk("arst_ovf",  32'(ovf),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (8) @(negedge clk);
        chk("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
        issue(16'h1111, 16'h2222, 1'b0, '{16'hEEEF, 1'b1, 1'b0});
        wait_done();

        for (int n = 0; n < 1000; n++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 16'h8000;
                1: rb = 16'hFFFF;
                2: rb = ra;
                default: ;
            endcase
            issue(ra, rb, rbi, model(ra, rb, rbi));
            wait_done();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
